// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter.
//   - WE encodings used on the requester and memory sides
//   - FSM state encoding for the arbiter
//   - nbytes(): access size in bytes for a given WE encoding
package mem_arb_pkg;

    // Bytes per memory word; the arbiter only supports 32-bit words.
    localparam int unsigned WORD_BYTES = 4;

    localparam logic [1:0] WE_READ = 2'b00;
    localparam logic [1:0] WE_WORD = 2'b01;
    localparam logic [1:0] WE_HALF = 2'b10;
    localparam logic [1:0] WE_BYTE = 2'b11;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StResp   = 2'd2
    } arb_state_e;

    // Number of bytes touched by an access; reads always fetch a full word.
    function automatic logic [3:0] nbytes(input logic [1:0] we);
        logic [3:0] n;
        case (we)
            WE_WORD: n = 4'(WORD_BYTES);
            WE_HALF: n = 4'(WORD_BYTES / 2);
            WE_BYTE: n = 4'(WORD_BYTES / 4);
            default: n = 4'(WORD_BYTES);
        endcase
        return n;
    endfunction

endpackage

// File: rtl/mem_access_check.sv
// Combinational range check for one memory access.
// Ports:
//   we   - access type (read / word / half / byte write)
//   addr - byte address of the first byte touched
//   err  - 1 when any byte of the access lies at or beyond MEM_BYTES
module mem_access_check
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_BYTES  = 256
) (
    input  logic [1:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  err
);

    // One extra bit so an address near the top of the space cannot wrap
    // around and look in range.
    logic [ADDR_WIDTH:0] end_addr;

    always_comb begin
        end_addr = {1'b0, addr} + {{(ADDR_WIDTH - 3){1'b0}}, nbytes(we)};
        err      = end_addr > (ADDR_WIDTH + 1)'(MEM_BYTES);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one byte-addressable data memory port between
// m0 (CPU load/store) and m1 (UART loader). One access at a time:
// IDLE (grant + latch command) -> ACCESS (memory cycle) -> RESP (ack pulse).
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   m0_req/we/addr/wd         - m0 command, req held until m0_ack
//   m0_ack/rd/err             - m0 one-cycle completion, read data, range error
//   m1_*                      - same as m0_* for m1
//   mem_we/addr/wd            - memory write enable, address, write data
//   mem_rd                    - memory combinational read data
//   busy                      - 1 whenever the FSM is not idle
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned BYTE_SIZE  = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_BYTES  = 256
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   m0_req,
    input  logic [1:0]             m0_we,
    input  logic [ADDR_WIDTH-1:0]  m0_addr,
    input  logic [BYTE_SIZE*8-1:0] m0_wd,
    output logic                   m0_ack,
    output logic [BYTE_SIZE*8-1:0] m0_rd,
    output logic                   m0_err,

    input  logic                   m1_req,
    input  logic [1:0]             m1_we,
    input  logic [ADDR_WIDTH-1:0]  m1_addr,
    input  logic [BYTE_SIZE*8-1:0] m1_wd,
    output logic                   m1_ack,
    output logic [BYTE_SIZE*8-1:0] m1_rd,
    output logic                   m1_err,

    output logic [1:0]             mem_we,
    output logic [ADDR_WIDTH-1:0]  mem_addr,
    output logic [BYTE_SIZE*8-1:0] mem_wd,
    input  logic [BYTE_SIZE*8-1:0] mem_rd,

    output logic                   busy
);

    localparam int unsigned DW = BYTE_SIZE * 8;

    arb_state_e            state_q;
    logic                  last_owner_q;  // 0 = m0, 1 = m1
    logic                  owner_q;
    logic [1:0]            cmd_we_q;
    logic [ADDR_WIDTH-1:0] cmd_addr_q;
    logic [DW-1:0]         cmd_wd_q;

    logic                  m0_ack_q, m1_ack_q;
    logic                  m0_err_q, m1_err_q;
    logic [DW-1:0]         m0_rd_q, m1_rd_q;

    logic                  grant_m1;
    logic                  acc_err;

    // m1 wins if it is the only requester, or on a tie when m0 was served last.
    assign grant_m1 = m1_req & (~m0_req | ~last_owner_q);

    mem_access_check #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_BYTES  (MEM_BYTES)
    ) u_check (
        .we   (cmd_we_q),
        .addr (cmd_addr_q),
        .err  (acc_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_owner_q <= 1'b1;
            owner_q      <= 1'b0;
            cmd_we_q     <= WE_READ;
            cmd_addr_q   <= '0;
            cmd_wd_q     <= '0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_err_q     <= 1'b0;
            m1_err_q     <= 1'b0;
            m0_rd_q      <= '0;
            m1_rd_q      <= '0;
        end else begin
            // Ack and err are single-cycle pulses; rd holds.
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            m0_err_q <= 1'b0;
            m1_err_q <= 1'b0;

            unique case (state_q)
                StIdle: begin
                    if (m0_req || m1_req) begin
                        owner_q      <= grant_m1;
                        last_owner_q <= grant_m1;
                        cmd_we_q     <= grant_m1 ? m1_we   : m0_we;
                        cmd_addr_q   <= grant_m1 ? m1_addr : m0_addr;
                        cmd_wd_q     <= grant_m1 ? m1_wd   : m0_wd;
                        state_q      <= StAccess;
                    end
                end
                StAccess: begin
                    // Capture the pre-write memory contents; errors read as zero.
                    if (owner_q) begin
                        m1_ack_q <= 1'b1;
                        m1_err_q <= acc_err;
                        m1_rd_q  <= acc_err ? '0 : mem_rd;
                    end else begin
                        m0_ack_q <= 1'b1;
                        m0_err_q <= acc_err;
                        m0_rd_q  <= acc_err ? '0 : mem_rd;
                    end
                    state_q <= StResp;
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Write enable is only live in ACCESS, and reset kills it in the same
    // cycle so an interrupted access cannot corrupt memory.
    always_comb begin
        mem_we = WE_READ;
        if (state_q == StAccess && !acc_err && !rst) begin
            mem_we = cmd_we_q;
        end
    end

    assign mem_addr = cmd_addr_q;
    assign mem_wd   = cmd_wd_q;

    // Reset during RESP cancels the ack that is already registered.
    assign m0_ack = m0_ack_q & ~rst;
    assign m1_ack = m1_ack_q & ~rst;
    assign m0_err = m0_err_q & ~rst;
    assign m1_err = m1_err_q & ~rst;
    assign m0_rd  = m0_rd_q;
    assign m1_rd  = m1_rd_q;

    assign busy = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, scoreboard-based bench for mem_port_arbiter with a 256-byte
// behavioural memory model attached to the memory port.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req, m1_req;
    logic [1:0]  m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wd, m1_wd;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] m0_rd, m1_rd;
    logic [1:0]  mem_we;
    logic [31:0] mem_addr, mem_wd, mem_rd;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit          owner;
        logic [31:0] rd;
        bit          chk_rd;
        bit          err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .BYTE_SIZE  (4),
        .ADDR_WIDTH (32),
        .MEM_BYTES  (256)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .m0_req   (m0_req),
        .m0_we    (m0_we),
        .m0_addr  (m0_addr),
        .m0_wd    (m0_wd),
        .m0_ack   (m0_ack),
        .m0_rd    (m0_rd),
        .m0_err   (m0_err),
        .m1_req   (m1_req),
        .m1_we    (m1_we),
        .m1_addr  (m1_addr),
        .m1_wd    (m1_wd),
        .m1_ack   (m1_ack),
        .m1_rd    (m1_rd),
        .m1_err   (m1_err),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wd   (mem_wd),
        .mem_rd   (mem_rd),
        .busy     (busy)
    );

    // Behavioural memory: addresses wrap at 256 bytes, combinational read.
    logic [7:0] mem [256];
    logic [7:0] a0, a1, a2, a3;
    assign a0 = mem_addr[7:0];
    assign a1 = mem_addr[7:0] + 8'd1;
    assign a2 = mem_addr[7:0] + 8'd2;
    assign a3 = mem_addr[7:0] + 8'd3;
    assign mem_rd = {mem[a3], mem[a2], mem[a1], mem[a0]};

    always @(posedge clk) begin
        case (mem_we)
            2'b01: begin
                mem[a0] <= mem_wd[7:0];
                mem[a1] <= mem_wd[15:8];
                mem[a2] <= mem_wd[23:16];
                mem[a3] <= mem_wd[31:24];
            end
            2'b10: begin
                mem[a0] <= mem_wd[7:0];
                mem[a1] <= mem_wd[15:8];
            end
            2'b11: mem[a0] <= mem_wd[7:0];
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: every ack must match the oldest scoreboard entry.
    always @(negedge clk) begin
        if (!rst && (m0_ack || m1_ack)) begin
            exp_t e;
            chk("ack_overlap", {31'd0, m0_ack & m1_ack}, 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_owner", {31'd0, m1_ack}, {31'd0, e.owner});
                chk("resp_err", {31'd0, (e.owner ? m1_err : m0_err)}, {31'd0, e.err});
                if (e.chk_rd) chk("resp_rd", e.owner ? m1_rd : m0_rd, e.rd);
            end
        end
    end

    // One complete request/ack transaction, checking latency and write cycles.
    task automatic access(input bit m, input logic [1:0] we, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input bit chk_rd, input bit exp_err);
        int n;
        int we_cycles;
        bit got;
        exp_t e;
        e.owner  = m;
        e.rd     = exp_rd;
        e.chk_rd = chk_rd;
        e.err    = exp_err;
        sb.push_back(e);
        @(posedge clk); #1;
        if (!m) begin
            m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wd = wd;
        end else begin
            m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wd = wd;
        end
        n = 0; we_cycles = 0; got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (mem_we != 2'b00) we_cycles++;
            if (m ? m1_ack : m0_ack) got = 1'b1;
        end
        chk("ack_latency", n, 3);
        chk("we_cycles", we_cycles, (we != 2'b00 && !exp_err) ? 1 : 0);
        @(posedge clk); #1;
        if (!m) m0_req = 1'b0; else m1_req = 1'b0;
    endtask

    initial begin
        int t_ack [4];
        bit o_ack [4];
        int nack;
        exp_t e;

        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wd = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wd = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);

        // Reset state
        chk("rst_m0_ack", {31'd0, m0_ack}, 32'd0);
        chk("rst_m1_ack", {31'd0, m1_ack}, 32'd0);
        chk("rst_m0_err", {31'd0, m0_err}, 32'd0);
        chk("rst_m1_err", {31'd0, m1_err}, 32'd0);
        chk("rst_m0_rd", m0_rd, 32'd0);
        chk("rst_m1_rd", m1_rd, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_mem_we", {30'd0, mem_we}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wd", mem_wd, 32'd0);

        // Single write then read
        access(0, 2'b01, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
        access(0, 2'b00, 32'h10, 32'h0, 32'hDEADBEEF, 1, 0);

        // Sub-word writes
        access(0, 2'b01, 32'h20, 32'h11223344, 32'h0, 0, 0);
        access(1, 2'b11, 32'h21, 32'h000000AA, 32'h0, 0, 0);
        access(0, 2'b00, 32'h20, 32'h0, 32'h1122AA44, 1, 0);
        access(1, 2'b10, 32'h22, 32'h0000BBCC, 32'h0, 0, 0);
        access(1, 2'b00, 32'h20, 32'h0, 32'hBBCCAA44, 1, 0);

        // Range errors and the top-of-memory boundary
        access(1, 2'b01, 32'hFC, 32'hCAFEF00D, 32'h0, 0, 0);
        access(1, 2'b01, 32'hFD, 32'h99999999, 32'h0, 0, 1);
        access(0, 2'b00, 32'hFC, 32'h0, 32'hCAFEF00D, 1, 0);
        access(1, 2'b11, 32'hFF, 32'h00000077, 32'h0, 0, 0);
        access(0, 2'b00, 32'hFC, 32'h0, 32'h77FEF00D, 1, 0);
        access(1, 2'b00, 32'hFFFFFFFE, 32'h0, 32'h0, 1, 1);

        // Contention: both requesters held from reset; tie goes to m0 first.
        @(posedge clk); #1;
        rst = 1'b1;
        m0_req = 1; m0_we = 2'b00; m0_addr = 32'h10;
        m1_req = 1; m1_we = 2'b00; m1_addr = 32'h20;
        for (int i = 0; i < 4; i++) begin
            e.owner = (i % 2) == 1;
            e.rd = e.owner ? 32'hBBCCAA44 : 32'hDEADBEEF;
            e.chk_rd = 1; e.err = 0;
            sb.push_back(e);
        end
        @(posedge clk); #1 rst = 1'b0;
        nack = 0;
        for (int c = 1; c <= 30 && nack < 4; c++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                t_ack[nack] = c;
                o_ack[nack] = m1_ack;
                nack++;
            end
        end
        chk("cont_nack", nack, 4);
        chk("cont_first_lat", t_ack[0], 3);
        for (int i = 1; i < 4; i++) begin
            chk("cont_spacing", t_ack[i] - t_ack[i-1], 3);
            chk("cont_alternate", {31'd0, o_ack[i]}, {31'd0, ~o_ack[i-1]});
        end
        @(posedge clk); #1;
        m0_req = 0; m1_req = 0;
        repeat (2) @(posedge clk);

        // Reset pulsed during the ACCESS cycle of a word write
        access(0, 2'b01, 32'h30, 32'h55667788, 32'h0, 0, 0);
        @(posedge clk); #1;
        m0_req = 1; m0_we = 2'b01; m0_addr = 32'h30; m0_wd = 32'h12345678;
        @(posedge clk); #1;
        chk("mid_state_busy", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_we", {30'd0, mem_we}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; m0_req = 0;
        @(negedge clk);
        chk("mid_busy_after", {31'd0, busy}, 32'd0);
        chk("mid_ack_after", {30'd0, m1_ack, m0_ack}, 32'd0);
        repeat (4) @(posedge clk);
        access(1, 2'b00, 32'h30, 32'h0, 32'h55667788, 1, 0);

        // Idle hold
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_we", {30'd0, mem_we}, 32'd0);
            chk("idle_busy", {31'd0, busy}, 32'd0);
            chk("idle_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
        end

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single byte-addressable data memory port (WE/ADDR/WD/RD) between two requesters: m0 = CPU load/store path, m1 = UART program/data loader.
- Round-robin arbitration, one access at a time, with a req/ack handshake per requester.
- Registered read-data return and an out-of-range error response.
- Sits between the requesters and the memory. It is the only driver of the memory's WE, ADDR and WD.

Parameters:
- BYTE_SIZE, 4, bytes per memory word; must be 4.
- ADDR_WIDTH, 32, byte address width.
- MEM_BYTES, 256, memory depth in bytes; the legal address range is 0..MEM_BYTES-1.

Ports:
- clk  in  1  clock; all state changes on its rising edge.
- rst  in  1  synchronous reset, active-high.
- m0_req  in  1  m0 access request; held until m0_ack.
- m0_we  in  2  00=read, 01=word write, 10=half write, 11=byte write.
- m0_addr  in  ADDR_WIDTH  byte address.
- m0_wd  in  BYTE_SIZE*8  write data, least significant byte at addr.
- m0_ack  out  1  one-cycle completion pulse.
- m0_rd  out  BYTE_SIZE*8  read data; valid while m0_ack=1.
- m0_err  out  1  valid while m0_ack=1; 1 = access rejected (out of range).
- m1_req, m1_we, m1_addr, m1_wd, m1_ack, m1_rd, m1_err: same widths and meanings as the m0 ports, for m1.
- mem_we  out  2  to memory WE.
- mem_addr  out  ADDR_WIDTH  to memory ADDR.
- mem_wd  out  BYTE_SIZE*8  to memory WD.
- mem_rd  in  BYTE_SIZE*8  from memory RD (combinational read).
- busy  out  1  1 when the FSM is not in IDLE.

Behaviour:
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any req=1, pick an owner and latch owner, we, addr and wd into command registers. Next state is ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - Only one req=1: that requester wins.
  - Both req=1: the requester that is not last_owner wins.
  - last_owner updates on each grant. It resets to 1, so m0 wins the first tie.
- ACCESS (exactly one cycle):
  - mem_addr and mem_wd are driven from the command registers.
  - mem_we = latched we, unless the access is in error or rst=1; then mem_we = 00.
  - Memory writes on this cycle's closing edge.
  - On the same edge, mem_rd is captured into the rdata register and the err flag is registered. Next state is RESP.
- Access size (nbytes) from we: 01 -> BYTE_SIZE, 10 -> BYTE_SIZE/2, 11 -> BYTE_SIZE/4, 00 (read) -> BYTE_SIZE.
- Error rule:
  - err = (addr + nbytes > MEM_BYTES), computed at ADDR_WIDTH+1 bits so large addresses cannot wrap to a false pass.
  - An erroring access never writes.
  - An erroring read returns rd = 0.
- RESP:
  - Owner's ack=1 for one cycle, with owner's rd and err valid.
  - The other requester's ack=0. Next state is IDLE.
  - req is ignored in RESP. A requester drops req, or presents a new command, after seeing ack; it is sampled again in IDLE.
- Latency and throughput:
  - req sampled in IDLE at cycle 0, memory access in cycle 1, ack in cycle 2.
  - One access per 3 cycles.
  - A requester that holds req continuously gets back-to-back grants whenever the other requester is idle.
- Outside ACCESS: mem_we = 00; mem_addr and mem_wd hold the last command-register value.
- m*_rd holds its last value when ack=0. m*_err = 0 when ack=0.
- Reset values:
  - state = IDLE, last_owner = 1.
  - All ack = 0, all err = 0, all rd = 0, busy = 0.
  - mem_we = 00, mem_addr = 0, mem_wd = 0.
- Reset mid-operation:
  - rst=1 during ACCESS forces mem_we = 00 combinationally, so no write occurs.
  - rst=1 during RESP cancels the pending ack, which is never delivered.
  - After rst deasserts, the FSM restarts from IDLE.
- Requester inputs changing while not granted or during ACCESS/RESP have no effect; the command registers hold.
- Misaligned addresses are passed through unchanged (the memory supports byte addressing). They are an error only if out of range.

Decomposition:
- Package mem_arb_pkg:
  - WE encodings WE_READ=2'b00, WE_WORD=2'b01, WE_HALF=2'b10, WE_BYTE=2'b11.
  - FSM state encoding IDLE/ACCESS/RESP.
  - Function nbytes(we).
- One sub-module, mem_access_check: combinational size decode plus range check; inputs we, addr; output err.
- Arbitration, FSM and response registers live in the top module.

Test Plan:
- Single write then read: m0 word write, addr 0x10, wd 0xDEADBEEF, then m0 read 0x10.
  - Write: m0_ack 2 cycles after req, mem_we=01 in exactly one cycle.
  - Read: m0_rd=0xDEADBEEF, m0_err=0.
- Sub-word write: word 0x11223344 at 0x20, then m1 byte write 0xAA to 0x21, then read 0x20 -> 0x1122AA44. Half write 0xBBCC to 0x22, then read 0x20 -> 0xBBCCAA44.
- Contention: m0_req and m1_req both held from reset.
  - Grants alternate m0, m1, m0, m1.
  - acks never overlap; each ack lasts 1 cycle; spacing is 3 cycles.
- Range error: m1 word write at addr 0xFD.
  - m1_err=1, mem_we stays 00, memory unchanged.
  - Byte write at 0xFF -> err=0.
  - Read at 0xFFFFFFFE -> err=1, rd=0.
- Reset mid-access: rst pulsed in the ACCESS cycle of a word write to 0x30.
  - No write; later read of 0x30 returns its prior value.
  - No ack; busy=0 the cycle after reset.
- Idle hold: no req for 10 cycles -> mem_we=00 throughout, busy=0, all acks 0.
